// File: rtl/conv_cfg_pkg.sv
// Shared layer constants, derived widths and common types for the first
// convolution layer's window scheduler.
package conv_cfg_pkg;

  localparam int N2_DEF      = 128;
  localparam int M2_DEF      = 128;
  localparam int C1_DEF      = 3;
  localparam int K_DEF       = 3;
  localparam int FILTERS_DEF = 32;
  localparam int ADDR_W_DEF  = 16;

  // Index width that never collapses to zero bits for a degenerate size of 1.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int TAPS_DEF  = K_DEF * K_DEF * C1_DEF;
  localparam int KER_W_DEF = clog2_min1(FILTERS_DEF);
  localparam int TAP_W_DEF = clog2_min1(TAPS_DEF);
  localparam int ROW_W_DEF = clog2_min1(N2_DEF);
  localparam int COL_W_DEF = clog2_min1(M2_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  pad;
    logic [KER_W_DEF-1:0]  ker;
    logic [TAP_W_DEF-1:0]  tap;
    logic                  first;
    logic                  last;
  } conv_tap_t;

endpackage

// File: rtl/conv_tap_addr.sv
// Maps an output pixel plus kernel tap to its source pixel: signed source
// coordinates, out-of-image flag and flat image-buffer address.
module conv_tap_addr
  import conv_cfg_pkg::*;
#(
  parameter int  N2     = N2_DEF,
  parameter int  M2     = M2_DEF,
  parameter int  C1     = C1_DEF,
  parameter int  K      = K_DEF,
  parameter int  ADDR_W = ADDR_W_DEF,
  localparam int ROW_W  = clog2_min1(N2),
  localparam int COL_W  = clog2_min1(M2),
  localparam int KY_W   = clog2_min1(K),
  localparam int CH_W   = clog2_min1(C1),
  localparam int SR_W   = ROW_W + 2,
  localparam int SC_W   = COL_W + 2
) (
  input  logic [ROW_W-1:0]        row,
  input  logic [COL_W-1:0]        col,
  input  logic [KY_W-1:0]         ky,
  input  logic [KY_W-1:0]         kx,
  input  logic [CH_W-1:0]         ch,
  output logic signed [SR_W-1:0]  src_row,
  output logic signed [SC_W-1:0]  src_col,
  output logic                    pad,
  output logic [ADDR_W-1:0]       img_addr
);

  localparam int                      PAD_AMT = (K - 1) / 2;
  localparam logic signed [SR_W-1:0]  PAD_R   = SR_W'(PAD_AMT);
  localparam logic signed [SC_W-1:0]  PAD_C   = SC_W'(PAD_AMT);
  localparam logic signed [SR_W-1:0]  N2_S    = SR_W'(N2);
  localparam logic signed [SC_W-1:0]  M2_S    = SC_W'(M2);
  localparam logic [ADDR_W-1:0]       M2_A    = ADDR_W'(M2);
  localparam logic [ADDR_W-1:0]       C1_A    = ADDR_W'(C1);

  logic [ADDR_W-1:0] lin_addr;

  // Two extra bits give room for both the sign and the far-edge overshoot.
  assign src_row = $signed(SR_W'(row)) + $signed(SR_W'(ky)) - PAD_R;
  assign src_col = $signed(SC_W'(col)) + $signed(SC_W'(kx)) - PAD_C;

  always_comb begin
    pad = (src_row < 0) || (src_row >= N2_S) || (src_col < 0) || (src_col >= M2_S);
    // In-image coordinates are non-negative and below N2/M2, so the low bits suffice.
    lin_addr = (ADDR_W'(src_row[ROW_W-1:0]) * M2_A + ADDR_W'(src_col[COL_W-1:0])) * C1_A
             + ADDR_W'(ch);
    img_addr = pad ? '0 : lin_addr;
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks filter, output pixel and kernel tap loops for one layer pass and
// emits one registered descriptor per tap over a valid/ready handshake.
module conv_window_scheduler
  import conv_cfg_pkg::*;
#(
  parameter int  N2_PARAM = N2_DEF,
  parameter int  M2_PARAM = M2_DEF,
  parameter int  C1_PARAM = C1_DEF,
  parameter int  K_PARAM  = K_DEF,
  parameter int  FILTERS  = FILTERS_DEF,
  parameter int  ADDR_W   = ADDR_W_DEF,
  localparam int TAPS     = K_PARAM * K_PARAM * C1_PARAM,
  localparam int KER_W    = clog2_min1(FILTERS),
  localparam int TAP_W    = clog2_min1(TAPS),
  localparam int ROW_W    = clog2_min1(N2_PARAM),
  localparam int COL_W    = clog2_min1(M2_PARAM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              tap_vld,
  input  logic              tap_rdy,
  output logic [ADDR_W-1:0] img_addr,
  output logic              pad,
  output logic [KER_W-1:0]  ker_idx,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              first_tap,
  output logic              last_tap,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col
);

  localparam int KY_W = clog2_min1(K_PARAM);
  localparam int CH_W = clog2_min1(C1_PARAM);

  sched_state_t state_q, state_d;

  logic [KER_W-1:0] fil_q, fil_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [KY_W-1:0]  ky_q,  ky_d;
  logic [KY_W-1:0]  kx_q,  kx_d;
  logic [CH_W-1:0]  ch_q,  ch_d;
  logic [TAP_W-1:0] tap_q, tap_d;

  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              vld_q,   vld_d;
  logic              pad_q,   pad_d;
  logic              first_q, first_d;
  logic              last_q,  last_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  logic                    handshake;
  logic                    carry;
  logic                    pass_end;
  logic                    pad_nxt;
  logic [ADDR_W-1:0]       addr_nxt;
  logic signed [ROW_W+1:0] src_row;
  logic signed [COL_W+1:0] src_col;
  logic                    src_unused;

  assign handshake = (state_q == S_RUN) && vld_q && tap_rdy;

  // Loop counters, innermost (ch) first; each level advances on the carry of the one inside it.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so 'carry' ripples through the chain in order.
    fil_d = fil_q;
    row_d = row_q;
    col_d = col_q;
    ky_d  = ky_q;
    kx_d  = kx_q;
    ch_d  = ch_q;
    tap_d = tap_q;
    carry = handshake;
    if (carry) tap_d = (tap_q == TAP_W'(TAPS - 1)) ? '0 : tap_q + TAP_W'(1);
    if (carry) ch_d  = (ch_q == CH_W'(C1_PARAM - 1)) ? '0 : ch_q + CH_W'(1);
    carry = carry && (ch_q == CH_W'(C1_PARAM - 1));
    if (carry) kx_d  = (kx_q == KY_W'(K_PARAM - 1)) ? '0 : kx_q + KY_W'(1);
    carry = carry && (kx_q == KY_W'(K_PARAM - 1));
    if (carry) ky_d  = (ky_q == KY_W'(K_PARAM - 1)) ? '0 : ky_q + KY_W'(1);
    carry = carry && (ky_q == KY_W'(K_PARAM - 1));
    if (carry) col_d = (col_q == COL_W'(M2_PARAM - 1)) ? '0 : col_q + COL_W'(1);
    carry = carry && (col_q == COL_W'(M2_PARAM - 1));
    if (carry) row_d = (row_q == ROW_W'(N2_PARAM - 1)) ? '0 : row_q + ROW_W'(1);
    carry = carry && (row_q == ROW_W'(N2_PARAM - 1));
    if (carry) fil_d = (fil_q == KER_W'(FILTERS - 1)) ? '0 : fil_q + KER_W'(1);
    pass_end = carry && (fil_q == KER_W'(FILTERS - 1));
  end

  // Address of the descriptor that will be presented after this edge.
  conv_tap_addr #(
    .N2     (N2_PARAM),
    .M2     (M2_PARAM),
    .C1     (C1_PARAM),
    .K      (K_PARAM),
    .ADDR_W (ADDR_W)
  ) u_tap_addr (
    .row      (row_d),
    .col      (col_d),
    .ky       (ky_d),
    .kx       (kx_d),
    .ch       (ch_d),
    .src_row  (src_row),
    .src_col  (src_col),
    .pad      (pad_nxt),
    .img_addr (addr_nxt)
  );

  // Source coordinates are only observed for debug; pad/img_addr carry the result.
  assign src_unused = ^{src_row, src_col};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (pass_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == S_RUN);
    vld_d   = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    pad_d   = 1'b0;
    addr_d  = '0;
    first_d = 1'b0;
    last_d  = 1'b0;
    if (vld_d) begin
      pad_d   = pad_nxt;
      addr_d  = addr_nxt;
      first_d = (tap_d == '0);
      last_d  = (tap_d == TAP_W'(TAPS - 1));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fil_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      ch_q    <= '0;
      tap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      pad_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      fil_q   <= fil_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      ch_q    <= ch_d;
      tap_q   <= tap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      pad_q   <= pad_d;
      first_q <= first_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  // Counters wrap to zero at the end of a pass, so they double as idle-zero index outputs.
  assign busy      = busy_q;
  assign done      = done_q;
  assign tap_vld   = vld_q;
  assign pad       = pad_q;
  assign img_addr  = addr_q;
  assign first_tap = first_q;
  assign last_tap  = last_q;
  assign ker_idx   = fil_q;
  assign tap_idx   = tap_q;
  assign out_row   = row_q;
  assign out_col   = col_q;

endmodule
